dmem_write_buffer: RTL and testbench
====================================

// Module: dmem_write_buffer
// PURPOSE
//  Posted-store buffer downstream of the ARM core's data-memory port.
//  Captures stores (MemWrite, ALUResult address, WriteData) in a small FIFO and drains them to dmem through a valid/ready port.
//  The core therefore never waits on a slow memory or MMIO write.
//  Stalls the core when the buffer is full, or when a load hits a pending store's word address.
//  Supports a flush request used before halting or dumping dmem.
// PARAMETERS
//  DEPTH  4   store entries, power of two, >=2
//  AW     32  address width
//  DW     32  data width
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  cpu_we      in   1   core store request (MemWrite)
//  cpu_re      in   1   core load request (MemtoReg path)
//  cpu_addr    in   AW  byte address (ALUResult)
//  cpu_wdata   in   DW  store data (WriteData)
//  cpu_stall   out  1   hold PC/pipeline this cycle
//  flush_req   in   1   level; request full drain
//  flush_done  out  1   1-cycle pulse when drained
//  mem_valid   out  1   head entry valid toward dmem
//  mem_ready   in   1   dmem accepts head this cycle
//  mem_addr    out  AW  head address
//  mem_wdata   out  DW  head data
//  count       out  $clog2(DEPTH)+1  occupancy (debug/bench)
// BEHAVIOUR
//  Reset (reset==0, async):
//   - count=0, rd_ptr=wr_ptr=0, mem_valid=0, flush_done=0, FSM=IDLE, storage contents don't-care.
//   - Pending stores are discarded and mem_valid drops immediately.
//  Push: cpu_we && !cpu_stall -> entry {cpu_addr,cpu_wdata} written at wr_ptr on the clock edge; wr_ptr wraps modulo DEPTH.
//  Pop:
//   - mem_valid && mem_ready -> rd_ptr advances (wraps).
//   - mem_valid = (count!=0); mem_addr/mem_wdata = entry[rd_ptr], stable while mem_valid && !mem_ready.
//  Simultaneous push and pop: count unchanged; a push into an empty buffer appears on mem_* the next cycle (latency 1).
//  Full: count==DEPTH && cpu_we -> cpu_stall=1, no push, even if a pop happens the same cycle.
//  Load hazard:
//   - cpu_re && !cpu_we && any valid entry has addr[AW-1:2]==cpu_addr[AW-1:2] -> cpu_stall=1 until that entry drains.
//   - Byte offset is ignored in the compare.
//  cpu_we && cpu_re together: the store rules apply; the read is ignored for hazard purposes.
//  cpu_stall is combinational from the inputs and the current state; it has no effect when the core is idle.
//  Flush FSM:
//   - IDLE --flush_req--> DRAIN.
//   - DRAIN: cpu_we is stalled (cpu_stall=1 on store); stay until count==0, then go to DONE.
//   - DONE: flush_done=1 for one cycle, then IDLE; if flush_req is still high, return to DRAIN.
//   - flush_req with count==0 in IDLE -> DRAIN -> DONE (pulse 2 cycles after the request).
//  Count never exceeds DEPTH nor underflows; pop is only possible when count!=0.
// STRUCTURE
//  Package proc_mem_pkg:
//   - wb_entry_t struct {logic [AW-1:0] addr; logic [DW-1:0] data;}
//   - wb_state_t enum {WB_IDLE, WB_DRAIN, WB_DONE}
//   - WORD_LSB=2 constant.
//  Sub-module wb_fifo_core: storage array, pointers, count, push/pop, parallel per-entry valid bits for the hazard compare.
//  Top level: stall logic, flush FSM, port mapping.
// TESTING
//  1 Store 0x10<-0xAA, mem_ready=1 -> next cycle mem_valid=1, addr=0x10, data=0xAA; popped that cycle; count back to 0.
//  2 mem_ready=0; 4 stores to 0x0,0x4,0x8,0xC; 5th store -> cpu_stall=1, count=4.
//    Raise mem_ready -> drain order 0x0,0x4,0x8,0xC, stall released the cycle after the first pop.
//  3 Pending store 0x24; load 0x26 -> cpu_stall=1 until 0x24 drains; load 0x28 -> cpu_stall=0.
//  4 count=3 with push and pop in the same cycle -> count stays 3; wr_ptr and rd_ptr wrap past DEPTH-1 with data intact.
//  5 flush_req with 2 entries and mem_ready=1 -> store during DRAIN stalled; flush_done pulses once after count==0.
//  6 reset low mid-drain (count=3) -> mem_valid=0 asynchronously; after release count=0, no spurious mem_valid.

Source files
------------

// File: rtl/proc_mem_pkg.sv
// Shared types for the data-memory posted-store buffer.
package proc_mem_pkg;

    localparam int WB_AW    = 32;
    localparam int WB_DW    = 32;
    // Address bits below this index select a byte within a word.
    localparam int WORD_LSB = 2;

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_DRAIN,
        WB_DONE
    } wb_state_t;

endpackage

// File: rtl/wb_fifo_core.sv
// Store FIFO: entry storage, pointers, occupancy and per-entry valid bits
// so a load address can be compared against every pending store at once.
module wb_fifo_core
    import proc_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [AW-1:0]         push_addr,
    input  logic [DW-1:0]         push_data,
    input  logic [AW-1-WORD_LSB:0] hz_word,
    output logic                  hit,
    output logic [AW-1:0]         head_addr,
    output logic [DW-1:0]         head_data,
    output logic [PW:0]           count
);

    wb_entry_t         mem_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW:0]       count_q;

    // Storage is never reset; the valid bits and count decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q].addr <= push_addr;
            mem_q[wr_ptr_q].data <= push_data;
        end
    end

    // Pointers, occupancy and valid bits; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q        <= wr_ptr_q + PW'(1);
                vld_q[wr_ptr_q] <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q        <= rd_ptr_q + PW'(1);
                vld_q[rd_ptr_q] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Word-address match against every pending entry.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (mem_q[i].addr[AW-1:WORD_LSB] == hz_word)) begin
                hit = 1'b1;
            end
        end
    end

    assign head_addr = mem_q[rd_ptr_q].addr;
    assign head_data = mem_q[rd_ptr_q].data;
    assign count     = count_q;

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-store buffer between the core's data port and dmem.
// Stalls the core on a full buffer, on a load that hits a pending store,
// and on stores while a flush is draining the buffer.
//
// state    | meaning
// WB_IDLE  | normal operation, no flush in progress
// WB_DRAIN | flush requested; stores held off until the buffer is empty
// WB_DONE  | buffer empty; flush_done pulses for this one cycle
module dmem_write_buffer
    import proc_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_we,
    input  logic          cpu_re,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    input  logic          flush_req,
    output logic          flush_done,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [PW:0]   count
);

    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    wb_state_t state_q;
    wb_state_t state_d;
    logic      push;
    logic      pop;
    logic      hit;
    logic      full;
    logic      store_block;
    logic      load_hazard;

    wb_fifo_core #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_addr (cpu_addr),
        .push_data (cpu_wdata),
        .hz_word   (cpu_addr[AW-1:WORD_LSB]),
        .hit       (hit),
        .head_addr (mem_addr),
        .head_data (mem_wdata),
        .count     (count)
    );

    // Stall decision; a full buffer blocks a store even if the head pops this cycle.
    always_comb begin
        full        = (count == CNT_FULL);
        store_block = cpu_we && (full || (state_q == WB_DRAIN));
        load_hazard = cpu_re && !cpu_we && hit;
        cpu_stall   = store_block || load_hazard;
        push        = cpu_we && !cpu_stall;
        mem_valid   = (count != '0);
        pop         = mem_valid && mem_ready;
    end

    // Flush FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush FSM next state and done pulse.
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (flush_req) state_d = WB_DRAIN;
            end
            WB_DRAIN: begin
                if (count == '0) state_d = WB_DONE;
            end
            WB_DONE: begin
                flush_done = 1'b1;
                state_d    = flush_req ? WB_DRAIN : WB_IDLE;
            end
            default: state_d = WB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer with hand-computed expectations.
module tb_dmem_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        flush_req;
    logic        flush_done;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    dmem_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_we     (cpu_we),
        .cpu_re     (cpu_re),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        tick();
        cpu_we = 1'b0;
    endtask

    initial begin
        reset = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        flush_req = 1'b0; mem_ready = 1'b0;
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(mem_valid), 64'd0);
        chk("rst_done", 64'(flush_done), 64'd0);
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        @(negedge clk); reset = 1'b1;
        tick();

        // 1: single store, pass-through with latency 1
        mem_ready = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hAA;
        #1 chk("t1_stall", 64'(cpu_stall), 64'd0);
        tick(); cpu_we = 1'b0; #1;
        chk("t1_valid", 64'(mem_valid), 64'd1);
        chk("t1_addr", 64'(mem_addr), 64'h10);
        chk("t1_data", 64'(mem_wdata), 64'hAA);
        chk("t1_count", 64'(count), 64'd1);
        tick();
        chk("t1_count0", 64'(count), 64'd0);
        chk("t1_valid0", 64'(mem_valid), 64'd0);

        // 2: fill, full stall, drain order
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) store(32'(i * 4), 32'h100 + 32'(i));
        cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1FF;
        #1;
        chk("t2_full_stall", 64'(cpu_stall), 64'd1);
        chk("t2_count4", 64'(count), 64'd4);
        chk("t2_head0", 64'(mem_addr), 64'h0);
        mem_ready = 1'b1; #1;
        chk("t2_stall_popcyc", 64'(cpu_stall), 64'd1);
        tick();
        chk("t2_count3", 64'(count), 64'd3);
        chk("t2_stall_rel", 64'(cpu_stall), 64'd0);
        chk("t2_head1", 64'(mem_addr), 64'h4);
        tick(); cpu_we = 1'b0; #1;
        chk("t2_pushpop_cnt", 64'(count), 64'd3);
        chk("t2_head2", 64'(mem_addr), 64'h8);
        chk("t2_data2", 64'(mem_wdata), 64'h102);
        tick();
        chk("t2_head3", 64'(mem_addr), 64'hC);
        tick();
        chk("t2_head4", 64'(mem_addr), 64'h10);
        chk("t2_data4", 64'(mem_wdata), 64'h1FF);
        tick();
        chk("t2_empty", 64'(count), 64'd0);

        // 3: load hazard on word address
        mem_ready = 1'b0;
        store(32'h24, 32'h55);
        cpu_re = 1'b1; cpu_addr = 32'h26; #1;
        chk("t3_hz_stall", 64'(cpu_stall), 64'd1);
        cpu_addr = 32'h28; #1;
        chk("t3_nohz", 64'(cpu_stall), 64'd0);
        cpu_we = 1'b1; cpu_addr = 32'h24; #1;
        chk("t3_we_re", 64'(cpu_stall), 64'd0);
        cpu_we = 1'b0; cpu_addr = 32'h26; mem_ready = 1'b1; #1;
        chk("t3_hz_popcyc", 64'(cpu_stall), 64'd1);
        tick();
        chk("t3_released", 64'(cpu_stall), 64'd0);
        chk("t3_count0", 64'(count), 64'd0);
        cpu_re = 1'b0;

        // 4: push+pop at count 3 with pointer wrap
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) store(32'hA0 + 32'(i * 4), 32'h300 + 32'(i));
        chk("t4_count3", 64'(count), 64'd3);
        chk("t4_head", 64'(mem_addr), 64'hA0);
        mem_ready = 1'b1;
        store(32'hAC, 32'h303);
        chk("t4_cnt_kept", 64'(count), 64'd3);
        chk("t4_wrap_a1", 64'(mem_addr), 64'hA4);
        chk("t4_wrap_d1", 64'(mem_wdata), 64'h301);
        tick();
        chk("t4_wrap_a2", 64'(mem_addr), 64'hA8);
        tick();
        chk("t4_wrap_a3", 64'(mem_addr), 64'hAC);
        chk("t4_wrap_d3", 64'(mem_wdata), 64'h303);
        tick();
        chk("t4_empty", 64'(count), 64'd0);

        // 5: flush with two pending entries
        mem_ready = 1'b0;
        store(32'h40, 32'h1); store(32'h44, 32'h2);
        flush_req = 1'b1; mem_ready = 1'b1; #1;
        chk("t5_done_early", 64'(flush_done), 64'd0);
        tick();
        cpu_we = 1'b1; cpu_addr = 32'h50; #1;
        chk("t5_drain_stall", 64'(cpu_stall), 64'd1);
        cpu_we = 1'b0;
        tick();
        chk("t5_count0", 64'(count), 64'd0);
        chk("t5_not_yet", 64'(flush_done), 64'd0);
        flush_req = 1'b0;
        tick();
        chk("t5_done", 64'(flush_done), 64'd1);
        tick();
        chk("t5_done_1cyc", 64'(flush_done), 64'd0);

        // flush on an empty buffer pulses two cycles after the request
        flush_req = 1'b1;
        tick(); flush_req = 1'b0; #1;
        chk("t5e_drain", 64'(flush_done), 64'd0);
        tick();
        chk("t5e_done", 64'(flush_done), 64'd1);
        tick();
        chk("t5e_idle", 64'(flush_done), 64'd0);

        // 6: async reset mid-drain
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) store(32'h60 + 32'(i * 4), 32'h600 + 32'(i));
        chk("t6_count3", 64'(count), 64'd3);
        mem_ready = 1'b1; #2;
        reset = 1'b0; #1;
        chk("t6_async_valid", 64'(mem_valid), 64'd0);
        chk("t6_async_count", 64'(count), 64'd0);
        @(negedge clk); reset = 1'b1; mem_ready = 1'b0;
        tick();
        chk("t6_post_valid", 64'(mem_valid), 64'd0);
        chk("t6_post_count", 64'(count), 64'd0);
        tick();
        chk("t6_post_valid2", 64'(mem_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
